// File: rtl/iir_pkg.sv
// Shared Q-format constants, FSM/select encodings and saturation helpers for iir_inv.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package iir_pkg;

  // Coefficients are Q1.17, so products are scaled back by 17 bits.
  localparam int COEF_FRAC = 17;

  localparam logic signed [17:0] INTERNAL_MAX = 18'sh1FFFF;  //  131071
  localparam logic signed [17:0] INTERNAL_MIN = 18'sh20000;  // -131072
  localparam logic signed [15:0] INOUT_MAX    = 16'sh7FFF;   //  32767
  localparam logic signed [15:0] INOUT_MIN    = 16'sh8000;   // -32768

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_HOLD
  } state_e;

  // Which coefficient/operand pair the shared multiplier works on this cycle.
  typedef enum logic [1:0] {
    SEL_G0_Y,
    SEL_G1_YD2,
    SEL_G2_XD1
  } mac_sel_e;

  // Clamp a 19-bit partial sum into the 18-bit accumulator range.
  function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
    logic signed [17:0] r;
    if (v[18] == v[17]) r = v[17:0];
    else if (v[18])     r = INTERNAL_MIN;
    else                r = INTERNAL_MAX;
    return r;
  endfunction

  // Clamp an 18-bit accumulator value into the 16-bit sample range.
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    logic signed [15:0] r;
    if ((&v[17:15]) || !(|v[17:15])) r = v[15:0];
    else if (v[17])                  r = INOUT_MIN;
    else                             r = INOUT_MAX;
    return r;
  endfunction

endpackage

// File: rtl/iir_inv_mac.sv
// Shared 18x16 multiply, Q1.17 rescale (floor) and saturating add onto the accumulator.
// Latency: purely combinational; the caller registers the result.
// Backpressure: none; evaluated every cycle, the FSM decides whether to keep it.
module iir_inv_mac
  import iir_pkg::*;
#(
  parameter logic signed [17:0] coef_g0 = 18'sd131071,
  parameter logic signed [17:0] coef_g1 = -18'sd22500,
  parameter logic signed [17:0] coef_g2 = 18'sd123586
) (
  input  mac_sel_e           sel_i,
  input  logic signed [17:0] acc_i,
  input  logic signed [15:0] y_in_i,
  input  logic signed [15:0] y_d2_i,
  input  logic signed [15:0] x_d1_i,
  output logic signed [17:0] sum_o
);

  logic signed [17:0] coef;
  logic signed [15:0] opnd;
  logic signed [33:0] prod;
  logic signed [18:0] term;
  logic signed [18:0] sum;

  // Steer one coefficient/operand pair onto the single multiplier.
  always_comb begin
    coef = coef_g0;
    opnd = y_in_i;
    case (sel_i)
      SEL_G0_Y:   begin coef = coef_g0; opnd = y_in_i; end
      SEL_G1_YD2: begin coef = coef_g1; opnd = y_d2_i; end
      SEL_G2_XD1: begin coef = coef_g2; opnd = x_d1_i; end
      default:    begin coef = coef_g0; opnd = y_in_i; end
    endcase
  end

  // Full-precision product; the arithmetic shift floors toward minus infinity.
  assign prod  = 34'(coef) * 34'(opnd);
  assign term  = 19'(prod >>> COEF_FRAC);
  assign sum   = 19'(acc_i) + term;
  assign sum_o = sat18(sum);

endmodule

// File: rtl/iir_inv.sv
// Inverse IIR equaliser: x[n] = g0*y[n] + g1*y[n-2] + g2*x[n-1], one shared multiplier.
// Latency: valid_o rises 3 cycles after the input handshake; one sample per 5 cycles max.
// Backpressure: HOLD keeps data_o/valid_o stable until ready_i; ready_o is low outside IDLE.
module iir_inv
  import iir_pkg::*;
#(
  parameter logic signed [17:0] coef_g0        = 18'sd131071,
  parameter logic signed [17:0] coef_g1        = -18'sd22500,
  parameter logic signed [17:0] coef_g2        = 18'sd123586,
  parameter int                 inout_width    = 16,
  parameter int                 internal_width = 18
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic signed [inout_width-1:0] data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic signed [inout_width-1:0] data_o,
  output logic                          valid_o,
  input  logic                          ready_i
);

  state_e                          state_q, state_d;
  logic signed [internal_width-1:0] acc_q, acc_d;
  logic signed [inout_width-1:0]    y_in_q, y_in_d;
  logic signed [inout_width-1:0]    y_d1_q, y_d1_d;
  logic signed [inout_width-1:0]    y_d2_q, y_d2_d;
  logic signed [inout_width-1:0]    x_d1_q, x_d1_d;
  logic signed [inout_width-1:0]    data_q, data_d;
  logic                             valid_q, valid_d;
  logic                             ready_q, ready_d;
  mac_sel_e                         mac_sel;
  logic signed [internal_width-1:0] mac_sum;

  iir_inv_mac #(
    .coef_g0 (coef_g0),
    .coef_g1 (coef_g1),
    .coef_g2 (coef_g2)
  ) u_mac (
    .sel_i  (mac_sel),
    .acc_i  (acc_q),
    .y_in_i (y_in_q),
    .y_d2_i (y_d2_q),
    .x_d1_i (x_d1_q),
    .sum_o  (mac_sum)
  );

  // Sequence the three MAC steps; history only advances on the output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    y_in_d  = y_in_q;
    y_d1_d  = y_d1_q;
    y_d2_d  = y_d2_q;
    x_d1_d  = x_d1_q;
    data_d  = data_q;
    valid_d = valid_q;
    mac_sel = SEL_G0_Y;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          y_in_d  = data_i;
          acc_d   = '0;
          state_d = S_MAC0;
        end
      end
      S_MAC0: begin
        mac_sel = SEL_G0_Y;
        acc_d   = mac_sum;
        state_d = S_MAC1;
      end
      S_MAC1: begin
        mac_sel = SEL_G1_YD2;
        acc_d   = mac_sum;
        state_d = S_MAC2;
      end
      S_MAC2: begin
        mac_sel = SEL_G2_XD1;
        acc_d   = mac_sum;
        data_d  = sat16(mac_sum);
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (valid_q && ready_i) begin
          y_d2_d  = y_d1_q;
          y_d1_d  = y_in_q;
          x_d1_d  = data_q;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // ready depends on state alone, never on valid_i/ready_i directly.
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers; reset drops any sample in flight and clears history.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      y_in_q  <= '0;
      y_d1_q  <= '0;
      y_d2_q  <= '0;
      x_d1_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      y_in_q  <= y_in_d;
      y_d1_q  <= y_d1_d;
      y_d2_q  <= y_d2_d;
      x_d1_q  <= x_d1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_iir_inv.sv
// Directed bench for iir_inv: reset, impulse, saturation, backpressure, mid-op reset, streaming.
// Latency: checks valid_o rising 3 cycles after each accept edge.
// Backpressure: drives ready_i low in HOLD and checks outputs stay stable.
module tb_iir_inv;

  logic               clk_i;
  logic               reset_i;
  logic signed [15:0] data_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [15:0] data_o;
  logic               valid_o;
  logic               ready_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_acc = 0;
  logic valid_seen = 1'b0;
  int outq[$];
  int acc_edges[$];

  iir_inv dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Handshake monitor, sampled on the falling edge; cyc+1 is the edge about to fire.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (valid_i && ready_o) begin
        acc_edges.push_back(cyc + 1);
        last_acc <= cyc + 1;
      end
      if (valid_o && !valid_seen) chk("latency", cyc - last_acc, 3);
      if (valid_o && ready_i) outq.push_back(int'(data_o));
    end
    valid_seen <= valid_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    outq.delete();
    acc_edges.delete();
  endtask

  task automatic send(input int s);
    int n;
    n = 0;
    valid_i = 1'b1;
    data_i  = 16'(s);
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    if (!ready_o) chk("send_timeout", 0, 1);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_outs(input int cnt);
    int n;
    n = 0;
    while (outq.size() < cnt && n < 300) begin
      tick();
      n++;
    end
    chk("out_count", outq.size(), cnt);
  endtask

  // Reference recurrence with explicit floor scaling and clamping.
  int m_y1, m_y2, m_x1;

  function automatic int clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  function automatic longint qmul(input longint c, input longint d);
    longint p;
    p = c * d;
    return p >>> 17;
  endfunction

  function automatic int model_step(input int y);
    longint a;
    int x;
    a = clamp(qmul(131071, y), -131072, 131071);
    a = clamp(a + qmul(-22500, m_y2), -131072, 131071);
    a = clamp(a + qmul(123586, m_x1), -131072, 131071);
    x = clamp(a, -32768, 32767);
    m_y2 = m_y1;
    m_y1 = y;
    m_x1 = x;
    return x;
  endfunction

  task automatic impulse(input string tag);
    int exp_v[3];
    exp_v[0] = 16383;
    exp_v[1] = 15447;
    exp_v[2] = 11751;
    outq.delete();
    ready_i = 1'b1;
    send(16384);
    send(0);
    send(0);
    wait_outs(3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_%0d", tag, i), (outq.size() > i) ? outq[i] : -99999, exp_v[i]);
  endtask

  initial begin
    int hold_v;
    int n;
    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;

    // Reset state
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);

    // Impulse response
    impulse("imp");

    // Positive saturation: first output 32766, then pinned at 32767
    do_reset();
    for (int i = 0; i < 6; i++) send(32767);
    wait_outs(6);
    chk("satp_0", outq.size() > 0 ? outq[0] : -99999, 32766);
    for (int i = 1; i < 6; i++)
      chk($sformatf("satp_%0d", i), outq.size() > i ? outq[i] : -99999, 32767);

    // Negative saturation
    do_reset();
    for (int i = 0; i < 6; i++) send(-32768);
    wait_outs(6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("satn_%0d", i), outq.size() > i ? outq[i] : -99999, -32768);

    // Backpressure in HOLD
    do_reset();
    ready_i = 1'b0;
    send(1000);
    n = 0;
    while (!valid_o && n < 50) begin
      tick();
      n++;
    end
    chk("bp_valid_up", int'(valid_o), 1);
    chk("bp_data", int'(data_o), 999);
    hold_v = int'(data_o);
    for (int i = 0; i < 10; i++) begin
      valid_i = i[0];
      data_i  = 16'sd555;
      tick();
      chk("bp_hold_valid", int'(valid_o), 1);
      chk("bp_hold_data", int'(data_o), hold_v);
      chk("bp_hold_ready", int'(ready_o), 0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk("bp_rel_valid", int'(valid_o), 0);
    chk("bp_rel_ready", int'(ready_o), 1);
    chk("bp_one_out", outq.size(), 1);
    chk("bp_accepts", acc_edges.size(), 1);

    // Reset while the sample sits in MAC1, then the impulse must reproduce exactly
    do_reset();
    ready_i = 1'b1;
    send(16384);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_ready", int'(ready_o), 1);
    impulse("imp2");

    // Streaming with both sides always willing
    do_reset();
    m_y1 = 0;
    m_y2 = 0;
    m_x1 = 0;
    ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      valid_i = 1'b1;
      data_i  = 16'(100 * (k + 1));
      n = 0;
      while (!ready_o && n < 50) begin
        tick();
        n++;
      end
      if (!ready_o) chk("stream_timeout", 0, 1);
      tick();
    end
    valid_i = 1'b0;
    wait_outs(8);
    for (int k = 1; k < 8; k++)
      chk("stream_gap", acc_edges.size() > k ? acc_edges[k] - acc_edges[k-1] : -1, 5);
    for (int k = 0; k < 8; k++)
      chk($sformatf("stream_%0d", k), outq.size() > k ? outq[k] : -99999,
          model_step(100 * (k + 1)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
